// File: rtl/nx_ram_1rw_arb_pkg.sv
// Shared types and the round-robin pick helper for the single-port RAM arbiter.
// Requester counts up to RR_MAX are supported by rr_pick.
package nx_ram_arb_pkg;

    localparam int RR_MAX = 8;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        INIT     = 2'd1,
        RUN      = 2'd2
    } state_e;

    // First set bit of valid searching ptr, ptr+1, ... modulo n.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] valid,
        input logic [2:0]        ptr,
        input int                n
    );
        logic [RR_MAX-1:0] g;
        logic [3:0]        s;
        logic [2:0]        idx;
        logic              hit;
        g   = '0;
        hit = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            s = {1'b0, ptr} + 4'(k);
            if (s >= 4'(n)) begin
                s = s - 4'(n);
            end
            idx = s[2:0];
            if (k < n && !hit && valid[idx]) begin
                g[idx] = 1'b1;
                hit    = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/nx_ram_1rw_arb_if.sv
// Requester-side bus of the RAM arbiter: packed per-requester request
// fields, one-hot grants and the shared read-response bus.
interface nx_ram_1rw_arb_if #(
    parameter int NUM_REQ  = 2,
    parameter int WIDTH    = 64,
    parameter int BWEWIDTH = WIDTH,
    parameter int AW       = 8
);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          req_we;
    logic [NUM_REQ*AW-1:0]       req_add;
    logic [NUM_REQ*WIDTH-1:0]    req_din;
    logic [NUM_REQ*BWEWIDTH-1:0] req_bwe;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [WIDTH-1:0]            rsp_dout;

    modport master (
        output req_valid, req_we, req_add, req_din, req_bwe,
        input  req_ready, rsp_valid, rsp_dout
    );

    modport slave (
        input  req_valid, req_we, req_add, req_din, req_bwe,
        output req_ready, rsp_valid, rsp_dout
    );

endinterface

// File: rtl/nx_ram_1rw_arb_rr.sv
// Reusable round-robin arbiter: one-hot grant from this cycle's valids,
// pointer moves past the winner whenever advance_i is high.
module nx_rr_arb
    import nx_ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;
    logic [RR_MAX-1:0] v8;
    logic [RR_MAX-1:0] g8;

    always_comb begin
        v8               = '0;
        v8[NUM_REQ-1:0]  = valid_i;
        g8               = rr_pick(v8, 3'(ptr_q), NUM_REQ);
        grant_o          = g8[NUM_REQ-1:0];
        ptr_d            = ptr_q;
        if (advance_i) begin
            for (int j = 0; j < RR_MAX; j++) begin
                if (g8[j]) begin
                    ptr_d = (j + 1 >= NUM_REQ) ? '0 : PW'(j + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/nx_ram_1rw_arb.sv
// Round-robin sharing of one single-port RAM among NUM_REQ requesters.
// Define NX_RAM_1RW_ARB_INIT_EN to sweep the array to INIT_VALUE after reset.
module nx_ram_1rw_arb
    import nx_ram_arb_pkg::*;
#(
    parameter int                   NUM_REQ    = 2,
    parameter int                   WIDTH      = 64,
    parameter int                   BWEWIDTH   = WIDTH,
    parameter int                   DEPTH      = 256,
    parameter logic [WIDTH-1:0]     INIT_VALUE = '0,
    localparam int                  AW         = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    nx_ram_1rw_arb_if.slave     bus,
    output logic                ram_cs,
    output logic                ram_we,
    output logic [AW-1:0]       ram_add,
    output logic [WIDTH-1:0]    ram_din,
    output logic [BWEWIDTH-1:0] ram_bwe,
    input  logic [WIDTH-1:0]    ram_dout,
    output logic                init_done
);

    state_e             state_q;
    state_e             state_d;
    logic               init_done_q;
    logic               init_done_d;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [NUM_REQ-1:0] rsp_valid_d;
    logic [NUM_REQ-1:0] arb_valid;
    logic [NUM_REQ-1:0] grant;

`ifdef NX_RAM_1RW_ARB_INIT_EN
    logic [AW-1:0]      init_add_q;
    logic [AW-1:0]      init_add_d;
`endif

    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
`ifdef NX_RAM_1RW_ARB_INIT_EN
        init_add_d  = init_add_q;
`endif
        case (state_q)
            RST_WAIT: begin
`ifdef NX_RAM_1RW_ARB_INIT_EN
                state_d    = INIT;
                init_add_d = '0;
`else
                state_d     = RUN;
                init_done_d = 1'b1;
`endif
            end
`ifdef NX_RAM_1RW_ARB_INIT_EN
            INIT: begin
                init_add_d = init_add_q + 1'b1;
                if (init_add_q == AW'(DEPTH - 1)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
`endif
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = RST_WAIT;
            end
        endcase
    end

    // Requests are invisible to the arbiter until the FSM reaches RUN.
    assign arb_valid = bus.req_valid & {NUM_REQ{state_q == RUN}};

    nx_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (arb_valid),
        .advance_i (1'b1),
        .grant_o   (grant)
    );

    always_comb begin
        ram_cs  = 1'b0;
        ram_we  = 1'b0;
        ram_add = '0;
        ram_din = '0;
        ram_bwe = '0;
`ifdef NX_RAM_1RW_ARB_INIT_EN
        if (state_q == INIT) begin
            ram_cs  = 1'b1;
            ram_we  = 1'b1;
            ram_add = init_add_q;
            ram_din = INIT_VALUE;
            ram_bwe = '1;
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                ram_cs  = 1'b1;
                ram_we  = bus.req_we[i];
                ram_add = bus.req_add[i*AW +: AW];
                ram_din = bus.req_din[i*WIDTH +: WIDTH];
                ram_bwe = bus.req_bwe[i*BWEWIDTH +: BWEWIDTH];
            end
        end
    end

    assign rsp_valid_d   = grant & ~bus.req_we;
    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dout  = (|rsp_valid_q) ? ram_dout : '0;
    assign init_done     = init_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_WAIT;
            init_done_q <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef NX_RAM_1RW_ARB_INIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_add_q <= '0;
        end else begin
            init_add_q <= init_add_d;
        end
    end
`endif

endmodule
